// File: rtl/sample_sched_pkg.sv
// Shared types and default widths for the sample scheduler.
package sample_sched_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_PER_WIDTH  = 16;
  localparam int unsigned DEF_DROP_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/sample_timer.sv
// Loadable period down-counter; tick fires on the last cycle of each period and reloads.
module sample_timer
  import sample_sched_pkg::*;
#(
  parameter int unsigned PER_WIDTH = DEF_PER_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [PER_WIDTH-1:0] load_val_i,
  input  logic [PER_WIDTH-1:0] reload_val_i,
  input  logic                 en_i,
  output logic                 tick_o
);

  logic [PER_WIDTH-1:0] cnt_q, cnt_d;
  logic                 last;

  // A zero count is treated like the final cycle so a stray enable can never wrap.
  assign last   = (cnt_q == PER_WIDTH'(1)) || (cnt_q == '0);
  assign tick_o = en_i && (cnt_q == PER_WIDTH'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = last ? reload_val_i : cnt_q - PER_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sample_sched.sv
// Window controller for the counter->FIFO sample path: periodic snapshots, drop counting, stream glue.
module sample_sched
  import sample_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PER_WIDTH  = DEF_PER_WIDTH,
  parameter int unsigned DROP_WIDTH = DEF_DROP_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  abort_i,
  input  logic [PER_WIDTH-1:0]  period_i,
  input  logic [DATA_WIDTH-1:0] cnt_q_i,
  output logic                  cnt_en_o,
  output logic                  cnt_clear_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_push_o,
  output logic [DATA_WIDTH-1:0] fifo_data_o,
  output logic                  fifo_pop_o,
  output logic                  fifo_flush_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [DROP_WIDTH-1:0] drop_cnt_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam logic [DROP_WIDTH-1:0] DROP_MAX = {DROP_WIDTH{1'b1}};

  sched_state_e          state_q, state_d;
  logic [PER_WIDTH-1:0]  period_q, period_d;
  logic [DROP_WIDTH-1:0] drop_q, drop_d;
  logic [PER_WIDTH-1:0]  period_eff;
  logic                  timer_load, timer_en, tick;
  logic                  clear, flush, push, done;

  assign period_eff = (period_i == '0) ? PER_WIDTH'(1) : period_i;
  assign timer_en   = (state_q == RUN) && !abort_i;

  sample_timer #(
    .PER_WIDTH(PER_WIDTH)
  ) u_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .load_i       (timer_load),
    .load_val_i   (period_eff),
    .reload_val_i (period_q),
    .en_i         (timer_en),
    .tick_o       (tick)
  );

  // Next-state and control decode; abort outranks start, stop and tick.
  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    drop_d     = drop_q;
    timer_load = 1'b0;
    clear      = 1'b0;
    flush      = 1'b0;
    push       = 1'b0;
    done       = 1'b0;
    if (abort_i) begin
      flush   = 1'b1;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            clear      = 1'b1;
            flush      = 1'b1;
            period_d   = period_eff;
            timer_load = 1'b1;
            drop_d     = '0;
            state_d    = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (!fifo_full_i) begin
              push = 1'b1;
            end else if (drop_q != DROP_MAX) begin
              drop_d = drop_q + DROP_WIDTH'(1);
            end
          end
          if (stop_i) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty_i) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      period_q <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      drop_q   <= drop_d;
    end
  end

  assign cnt_en_o     = (state_q == RUN);
  assign cnt_clear_o  = clear;
  assign fifo_flush_o = flush;
  assign fifo_push_o  = push;
  assign fifo_data_o  = cnt_q_i;
  assign out_valid_o  = !fifo_empty_i;
  assign out_data_o   = fifo_data_i;
  assign fifo_pop_o   = out_valid_o && out_ready_i && !flush;
  assign drop_cnt_o   = drop_q;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done;

endmodule

// File: tb/tb_sample_sched.sv
// Directed bench for sample_sched with a behavioural counter and 4-deep FIFO around it.
module tb_sample_sched;

  typedef struct packed {
    logic       en;
    logic       clr;
    logic       flush;
    logic       push;
    logic [7:0] wdata;
    logic       valid;
    logic [7:0] odata;
    logic       pop;
    logic       busy;
    logic       done;
    logic [7:0] drop;
  } out_t;

  typedef struct packed {
    logic  start;
    logic  stop;
    logic  ready;
    out_t  exp;
  } vec_t;

  logic        clk, rst_n;
  logic        start, stop, abort, oready;
  logic [15:0] period;
  logic [7:0]  cnt_q, fdata_r, fdata_w, odata, drop;
  logic        cnt_en, cnt_clr, ffull, fempty, fpush, fpop, fflush, ovalid, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  sample_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .stop_i       (stop),
    .abort_i      (abort),
    .period_i     (period),
    .cnt_q_i      (cnt_q),
    .cnt_en_o     (cnt_en),
    .cnt_clear_o  (cnt_clr),
    .fifo_full_i  (ffull),
    .fifo_empty_i (fempty),
    .fifo_data_i  (fdata_r),
    .fifo_push_o  (fpush),
    .fifo_data_o  (fdata_w),
    .fifo_pop_o   (fpop),
    .fifo_flush_o (fflush),
    .out_valid_o  (ovalid),
    .out_ready_i  (oready),
    .out_data_o   (odata),
    .drop_cnt_o   (drop),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural max_counter stand-in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_en)  cnt_q <= cnt_q + 8'd1;
  end

  // Behavioural 4-deep registered FIFO; head reads as 0 when empty.
  logic [7:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  assign ffull   = (count == 3'd4);
  assign fempty  = (count == 3'd0);
  assign fdata_r = fempty ? 8'd0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (fflush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fpush && !ffull) begin
        mem[wr_ptr] <= fdata_w;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (fpop && !fempty) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'((fpush && !ffull) ? 1 : 0) - 3'((fpop && !fempty) ? 1 : 0);
    end
  end

  function automatic out_t mk(input logic en, input logic clr, input logic fl, input logic push,
                              input logic [7:0] wd, input logic valid, input logic [7:0] od,
                              input logic pop, input logic bsy, input logic dn, input logic [7:0] dr);
    out_t o;
    o = '{en, clr, fl, push, wd, valid, od, pop, bsy, dn, dr};
    return o;
  endfunction

  function automatic out_t get_out();
    out_t o;
    o = '{cnt_en, cnt_clr, fflush, fpush, fdata_w, ovalid, odata, fpop, busy, done, drop};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic p, input logic a, input logic [15:0] per,
                       input logic r);
    @(negedge clk);
    start  = s;
    stop   = p;
    abort  = a;
    period = per;
    oready = r;
    #1;
  endtask

  vec_t vecs [13];

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    abort  = 1'b0;
    period = 16'd0;
    oready = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'd0,  0, 8'd0, 0, 0, 0, 8'd0)};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd0,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd1,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 8'd2,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd3,  1, 8'd2, 1, 1, 0, 8'd0)};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd4,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 8'd5,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd6,  1, 8'd5, 1, 1, 0, 8'd0)};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'd7,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, mk(1, 0, 0, 1, 8'd8,  0, 8'd0, 0, 1, 0, 8'd0)};
    vecs[10] = '{1'b0, 1'b1, 1'b1, mk(1, 0, 0, 0, 8'd9,  1, 8'd8, 1, 1, 0, 8'd0)};
    vecs[11] = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd10, 0, 8'd0, 0, 1, 1, 8'd0)};
    vecs[12] = '{1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 8'd10, 0, 8'd0, 0, 0, 0, 8'd0)};

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", get_out(), mk(0, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;

    // Period 3 window, ready held high.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].start, vecs[i].stop, 1'b0, 16'd3, vecs[i].ready);
      chk($sformatf("p3_row%0d", i), get_out(), vecs[i].exp);
    end

    // Period 0 behaves as period 1: push every RUN cycle, stream steps by one.
    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b0, (i == 5), 1'b0, 16'd0, 1'b1);
      chk($sformatf("p0_push%0d", i), {fpush, fdata_w}, {1'b1, 8'(i - 1)});
      if (i >= 2) chk($sformatf("p0_stream%0d", i), {ovalid, odata}, {1'b1, 8'(i - 2)});
    end
    drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("p0_drain_first", {cnt_en, ovalid, odata, fpop, done}, {1'b0, 1'b1, 8'd4, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("p0_drain_done", {busy, done, fpush}, {1'b1, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("p0_idle", {busy, done}, {1'b0, 1'b0});

    // Ready low, period 1: fill four entries, then every tick is a drop.
    drive(1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
      if (i <= 4) chk($sformatf("fill_push%0d", i), {fpush, drop}, {1'b1, 8'd0});
      else        chk($sformatf("fill_drop%0d", i), {fpush, drop}, {1'b0, 8'(i - 5)});
    end
    repeat (260) drive(1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    chk("drop_saturated", {fpush, drop}, {1'b0, 8'hFF});

    // Abort with a full queue: flush, no pop or push, straight to IDLE.
    drive(1'b0, 1'b0, 1'b1, 16'd1, 1'b1);
    chk("abort_cycle", {fflush, fpop, fpush, ovalid, done}, {1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
    chk("abort_after", {busy, ovalid, done, fflush, drop}, {1'b0, 1'b0, 1'b0, 1'b0, 8'hFF});

    // Stop coincident with a tick still pushes, then DRAIN empties and signals done.
    drive(1'b1, 1'b0, 1'b0, 16'd2, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 16'd2, 1'b0);
    chk("restart_drop_clr", {busy, fpush, drop}, {1'b1, 1'b0, 8'd0});
    drive(1'b0, 1'b1, 1'b0, 16'd2, 1'b0);
    chk("stop_tick_push", {fpush, fdata_w}, {1'b1, 8'd1});
    drive(1'b0, 1'b0, 1'b0, 16'd2, 1'b1);
    chk("stop_drain_pop", {cnt_en, busy, ovalid, odata, fpop, done},
        {1'b0, 1'b1, 1'b1, 8'd1, 1'b1, 1'b0});
    drive(1'b1, 1'b0, 1'b0, 16'd2, 1'b1);
    chk("stop_drain_done", {busy, done, cnt_clr}, {1'b1, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'd2, 1'b1);
    chk("stop_idle", {busy, done}, {1'b0, 1'b0});

    // Asynchronous reset mid-window with drops pending, then a clean restart.
    drive(1'b1, 1'b0, 1'b0, 16'd1, 1'b0);
    repeat (6) drive(1'b0, 1'b0, 1'b0, 16'd1, 1'b0);
    chk("pre_reset_drop", 32'(drop), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", get_out(), mk(0, 0, 0, 0, 8'd0, 0, 8'd0, 0, 0, 0, 8'd0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'd3, 1'b1);
    chk("restart_start", {cnt_clr, fflush, busy}, {1'b1, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
    chk("restart_run", {busy, cnt_en}, {1'b1, 1'b1});
    drive(1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 16'd3, 1'b1);
    chk("restart_push", {fpush, fdata_w}, {1'b1, 8'd2});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
